// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream and IMEM write port for instr_encoder_loader.
//
// Signal groups:
//   field stream : in_valid, in_ready, last, in_class, in_func, in_rd, in_rs1, in_rs2, in_imm
//   imem write   : imem_valid, imem_ready, imem_addr, imem_wdata
//
// Modports:
//   slave  - the loader. It receives field bundles and issues IMEM writes.
//   master - the loader's environment (boot/debug front end plus IMEM).
interface instr_encoder_loader_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  last;
  logic [3:0]            in_class;
  logic [3:0]            in_func;
  logic [3:0]            in_rd;
  logic [3:0]            in_rs1;
  logic [3:0]            in_rs2;
  logic [15:0]           in_imm;
  logic                  imem_valid;
  logic                  imem_ready;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  in_valid, last, in_class, in_func, in_rd, in_rs1, in_rs2, in_imm, imem_ready,
    output in_ready, imem_valid, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, last, in_class, in_func, in_rd, in_rs1, in_rs2, in_imm, imem_ready,
    input  in_ready, imem_valid, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs instruction fields into 32-bit decoder-format
// words and writes them to consecutive IMEM addresses during program load.
// Illegal class/func combinations are dropped and counted.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   start         load base_addr and enter RUN (only from IDLE or DONE)
//   base_addr     first IMEM word address
//   bus           field stream in, IMEM write requests out (slave modport)
//   busy, done    status (busy in RUN/DRAIN, done in DONE)
//   err_illegal   sticky: a bundle was dropped since start
//   err_count     saturating count of dropped bundles
//   addr_wrap     sticky: address counter wrapped past all-ones
//   checksum      rotl-xor checksum of completed writes
//
// Build option: define ENC_CHECKSUM_EN to generate the checksum; when it is
// undefined checksum is tied to 0.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  instr_encoder_loader_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_illegal,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  addr_wrap,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic is_legal(input logic [3:0] cls, input logic [3:0] fn);
    logic ok;
    case (cls)
      4'b1100:          ok = fn inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
      4'b0100:          ok = fn inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
      4'b1101, 4'b0101: ok = fn inside {4'd0, 4'd3, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12, 4'd15};
      4'b0010:          ok = fn inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd9,
                                        4'd10, 4'd11, 4'd12, 4'd14, 4'd15};
      4'b0011, 4'b0111, 4'b0110: ok = (fn == 4'd0);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] cls, input logic [3:0] fn,
                                         input logic [3:0] rd, input logic [3:0] rs1,
                                         input logic [3:0] rs2, input logic [15:0] imm);
    logic [31:0] w;
    case (cls)
      4'b1100, 4'b1101: w = {cls, fn, rd, rs1, rs2, 12'h000};
      4'b0011, 4'b0010: w = {cls, fn, rs1, rs2, imm};
      default:          w = {cls, fn, rd, rs1, imm};
    endcase
    return w;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] fa_q [2];
  logic [ADDR_WIDTH-1:0] fa_d [2];
  logic [31:0]           fw_q [2];
  logic [31:0]           fw_d [2];
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  err_q, err_d, wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0]  ecnt_q, ecnt_d;

  logic in_ready_w, imem_valid_w, accept, legal, push, pop, start_go;

  // Gating with reset keeps the reset cycle itself free of handshakes.
  assign in_ready_w   = (state_q == S_RUN) && (cnt_q != 2'd2) && !reset;
  assign imem_valid_w = (cnt_q != 2'd0) && !reset;
  assign accept       = bus.in_valid && in_ready_w;
  assign legal        = is_legal(bus.in_class, bus.in_func);
  assign push         = accept && legal;
  assign pop          = imem_valid_w && bus.imem_ready;
  assign start_go     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign bus.in_ready   = in_ready_w;
  assign bus.imem_valid = imem_valid_w;
  assign bus.imem_addr  = fa_q[rd_ptr_q];
  assign bus.imem_wdata = fw_q[rd_ptr_q];
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_illegal    = err_q;
  assign err_count      = ecnt_q;
  assign addr_wrap      = wrap_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    fa_d     = fa_q;
    fw_d     = fw_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q;
    ecnt_d   = ecnt_q;
    wrap_d   = wrap_q;
    if (push) begin
      fa_d[wr_ptr_q] = addr_q;
      fw_d[wr_ptr_q] = encode(bus.in_class, bus.in_func, bus.in_rd, bus.in_rs1,
                              bus.in_rs2, bus.in_imm);
      wr_ptr_d       = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_go) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          err_d   = 1'b0;
          ecnt_d  = '0;
          wrap_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (legal) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (&addr_q) wrap_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (!(&ecnt_q)) ecnt_d = ecnt_q + CNT_WIDTH'(1);
          end
          if (bus.last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (cnt_q == 2'd0) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      fa_q     <= '{default: '0};
      fw_q     <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      fa_q     <= fa_d;
      fw_q     <= fw_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Pop never coincides with start: the FIFO is empty in IDLE and DONE.
  always_comb begin
    csum_d = csum_q;
    if (start_go)  csum_d = 32'h0;
    else if (pop)  csum_d = {csum_q[30:0], csum_q[31]} ^ fw_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= 32'h0;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] base_addr;
  logic        busy, done, err_illegal, addr_wrap;
  logic [7:0]  err_count;
  logic [31:0] checksum;

  int tests = 0;
  int fails = 0;
  int n_writes = 0;
  logic [31:0] cs_model = 32'h0;
  logic [42:0] sb[$];
  logic        held_v = 1'b0;
  logic [42:0] held;

  instr_encoder_loader_if #(.ADDR_WIDTH(11)) bif ();

  instr_encoder_loader #(.ADDR_WIDTH(11), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .bus(bif),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_count(err_count),
    .addr_wrap(addr_wrap), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor and scoreboard: sampled on the falling edge, the handshake
  // completes at the following rising edge.
  always @(negedge clk) begin
    if (held_v && bif.imem_valid)
      chk("hold_stable", {bif.imem_addr, bif.imem_wdata}, held);
    if (bif.imem_valid && bif.imem_ready) begin
      n_writes++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_write: observed %0h expected none", {bif.imem_addr, bif.imem_wdata});
      end else begin
        logic [42:0] e;
        e = sb.pop_front();
        chk("imem_addr", bif.imem_addr, e[42:32]);
        chk("imem_wdata", bif.imem_wdata, e[31:0]);
      end
`ifdef ENC_CHECKSUM_EN
      cs_model = {cs_model[30:0], cs_model[31]} ^ bif.imem_wdata;
`endif
    end
    held_v = bif.imem_valid && !bif.imem_ready;
    held   = {bif.imem_addr, bif.imem_wdata};
  end

  task automatic do_start(input logic [10:0] a);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = a;
    cs_model = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] c, input logic [3:0] f, input logic [3:0] rd,
                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm,
                      input logic lst, input logic legal, input logic [10:0] ea,
                      input logic [31:0] ew);
    int n;
    n = 0;
    bif.in_valid = 1'b1; bif.last = lst;
    bif.in_class = c; bif.in_func = f; bif.in_rd = rd;
    bif.in_rs1 = rs1; bif.in_rs2 = rs2; bif.in_imm = imm;
    forever begin
      @(negedge clk);
      if (bif.in_ready) break;
      n++;
      if (n > 40) begin
        tests++;
        fails++;
        $error("FAIL send_timeout: observed in_ready=0 expected 1");
        bif.in_valid = 1'b0;
        return;
      end
    end
    if (legal) sb.push_back({ea, ew});
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    bif.last = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; base_addr = '0;
    bif.in_valid = 1'b0; bif.last = 1'b0; bif.in_class = '0; bif.in_func = '0;
    bif.in_rd = '0; bif.in_rs1 = '0; bif.in_rs2 = '0; bif.in_imm = '0;
    bif.imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bif.in_ready, 1'b0);
    chk("rst_imem_valid", bif.imem_valid, 1'b0);
    chk("rst_imem_addr", bif.imem_addr, 11'h0);
    chk("rst_imem_wdata", bif.imem_wdata, 32'h0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_errs", {err_illegal, err_count, addr_wrap}, 10'h0);
    chk("rst_checksum", checksum, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD r3,r1,r2, single write then done
    do_start(11'h010);
    chk("start_busy", busy, 1'b1);
    w0 = n_writes;
    send(4'hC, 4'h7, 4'd3, 4'd1, 4'd2, 16'h0, 1'b1, 1'b1, 11'h010, 32'hC7312000);
    @(negedge clk);
    chk("add_latency", bif.imem_valid, 1'b1);
    wait_done("add_done");
    chk("add_writes", n_writes - w0, 1);
    chk("add_checksum", checksum, cs_model);

    // Mixed stream
    do_start(11'h000);
    chk("restart_done_clear", done, 1'b0);
    send(4'h4, 4'h7, 4'd4, 4'd0, 4'd0, 16'hBEEF, 1'b0, 1'b1, 11'h000, 32'h4740BEEF);
    send(4'h2, 4'h6, 4'd0, 4'd1, 4'd2, 16'hFFFE, 1'b0, 1'b1, 11'h001, 32'h2612FFFE);
    send(4'h6, 4'h0, 4'd15, 4'd8, 4'd0, 16'h0000, 1'b1, 1'b1, 11'h002, 32'h60F80000);
    wait_done("mix_done");
    chk("mix_sb_empty", sb.size(), 0);
    chk("mix_checksum", checksum, cs_model);
    chk("mix_err_count", err_count, 8'd0);

    // Illegal drops
    do_start(11'h020);
    w0 = n_writes;
    send(4'hF, 4'h0, 4'd1, 4'd1, 4'd1, 16'h1234, 1'b0, 1'b0, 11'h0, 32'h0);
    send(4'hC, 4'h3, 4'd1, 4'd1, 4'd1, 16'h0, 1'b0, 1'b0, 11'h0, 32'h0);
    send(4'hC, 4'h0, 4'd5, 4'd6, 4'd7, 16'h0, 1'b1, 1'b1, 11'h020, 32'hC0567000);
    wait_done("ill_done");
    chk("ill_err_count", err_count, 8'd2);
    chk("ill_err_illegal", err_illegal, 1'b1);
    chk("ill_writes", n_writes - w0, 1);

    // Illegal last ends the load; start clears errors
    do_start(11'h030);
    chk("start_clears_err", {err_illegal, err_count}, 9'h0);
    send(4'h3, 4'h1, 4'd0, 4'd1, 4'd2, 16'h0, 1'b1, 1'b0, 11'h0, 32'h0);
    wait_done("ill_last_done");
    chk("ill_last_cnt", err_count, 8'd1);

    // Backpressure
    bif.imem_ready = 1'b0;
    do_start(11'h100);
    w0 = n_writes;
    for (int i = 0; i < 2; i++)
      send(4'h4, 4'h0, 4'(i), 4'(i), 4'h0, 16'h1000 + 16'(i), 1'b0, 1'b1,
           11'h100 + 11'(i), {8'h40, 4'(i), 4'(i), 16'h1000 + 16'(i)});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", bif.in_ready, 1'b0);
    end
    chk("bp_no_writes", n_writes - w0, 0);
    @(posedge clk); #1;
    bif.imem_ready = 1'b1;
    for (int i = 2; i < 4; i++)
      send(4'h4, 4'h0, 4'(i), 4'(i), 4'h0, 16'h1000 + 16'(i), 1'(i == 3), 1'b1,
           11'h100 + 11'(i), {8'h40, 4'(i), 4'(i), 16'h1000 + 16'(i)});
    wait_done("bp_done");
    chk("bp_writes", n_writes - w0, 4);
    chk("bp_checksum", checksum, cs_model);

    // Address wrap
    do_start(11'h7FF);
    send(4'h5, 4'h3, 4'd1, 4'd2, 4'd0, 16'h00AA, 1'b0, 1'b1, 11'h7FF, 32'h531200AA);
    send(4'h7, 4'h0, 4'd9, 4'd10, 4'd0, 16'h0040, 1'b1, 1'b1, 11'h000, 32'h709A0040);
    wait_done("wrap_done");
    chk("wrap_flag", addr_wrap, 1'b1);

    // Reset mid-RUN with two words buffered
    bif.imem_ready = 1'b0;
    do_start(11'h040);
    send(4'hC, 4'h7, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0, 1'b1, 11'h040, 32'hC7312000);
    send(4'h4, 4'h7, 4'd4, 4'd0, 4'd0, 16'hBEEF, 1'b0, 1'b1, 11'h041, 32'h4740BEEF);
    sb.delete();
    w0 = n_writes;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_valid_cycle", bif.imem_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", bif.imem_valid, 1'b0);
    chk("rstmid_idle", {busy, done, bif.in_ready}, 3'b000);
    chk("rstmid_checksum", checksum, 32'h0);
    bif.imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_no_writes", n_writes - w0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
